// File: rtl/kronos_pkg.sv
// kronos_pkg: shared instruction formats, operand lanes and issue-queue entry type
package kronos_pkg;

    localparam int KRONOS_FUNCT7_MAX = 39;
    localparam int KRONOS_MAX_LANES  = 4;
    localparam int KRONOS_MAX_ID_W   = 8;

    typedef enum logic [6:0] {
        kronos_I  = 7'h0B,
        kronos_R  = 7'h3B,
        kronos_R4 = 7'h4B
    } kronos_op;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } r_type_t;

    typedef struct packed {
        logic [11:0] imm;
        logic [4:0]  rs1;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [6:0]  opcode;
    } i_type_t;

    typedef struct packed {
        logic [4:0] rs3;
        logic [1:0] funct2;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } r4_type_t;

    typedef union packed {
        r_type_t  r;
        i_type_t  i;
        r4_type_t r4;
    } instruction_u;

    // rs1 occupies the least significant word of a lane
    typedef struct packed {
        logic [31:0] rs3;
        logic [31:0] rs2;
        logic [31:0] rs1;
    } lane_ops_t;

    // lanes above NUM_LANES and id bits above ID_W are always zero
    typedef struct packed {
        kronos_op                               opcode;
        logic [2:0]                             funct3;
        logic [6:0]                             funct7;
        logic [1:0]                             funct2;
        logic [11:0]                            imm;
        lane_ops_t [KRONOS_MAX_LANES-1:0]       ops;
        logic [KRONOS_MAX_ID_W-1:0]             id;
    } issue_entry_t;

endpackage

// File: rtl/kronos_instr_decode.sv
// kronos_instr_decode: legality check and field normalisation of one raw instruction
module kronos_instr_decode
    import kronos_pkg::*;
#(
    parameter int NUM_LANES  = 2,
    parameter int FUNCT7_MAX = KRONOS_FUNCT7_MAX,
    parameter int ID_W       = 4
) (
    input  logic [31:0]             instr,
    input  logic [NUM_LANES*96-1:0] rs,
    input  logic [ID_W-1:0]         id,
    output logic                    legal,
    output issue_entry_t            entry
);
    instruction_u ins;
    logic         is_i;
    logic         is_r;
    logic         is_r4;
    logic         unused_fields;

    assign ins           = instr;
    assign is_i          = ins.r.opcode == kronos_I;
    assign is_r          = ins.r.opcode == kronos_R;
    assign is_r4         = ins.r.opcode == kronos_R4;
    assign unused_fields = ^{ins.r.rd, ins.r.rs1, ins.r.rs2};
    assign legal         = (is_i || is_r || is_r4) && ins.r.funct3 != 3'b000 &&
                           (!is_r || {25'd0, ins.r.funct7} <= FUNCT7_MAX);

    // keep only the fields meaningful for the format, zero the rest
    always_comb begin
        entry              = '0;
        entry.opcode       = kronos_op'(ins.r.opcode);
        entry.funct3       = ins.r.funct3;
        entry.funct7       = is_r ? ins.r.funct7 : 7'd0;
        entry.funct2       = is_r4 ? ins.r4.funct2 : 2'd0;
        entry.imm          = is_i ? ins.i.imm : 12'd0;
        for (int l = 0; l < NUM_LANES; l++) entry.ops[l] = rs[l*96 +: 96];
        entry.id[ID_W-1:0] = id;
    end

endmodule

// File: rtl/kronos_issue_queue.sv
// kronos_issue_queue: decoding FIFO that holds legal instructions until issue and reports illegal ones
module kronos_issue_queue
    import kronos_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int NUM_LANES  = 2,
    parameter int FUNCT7_MAX = KRONOS_FUNCT7_MAX,
    parameter int ID_W       = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     instr_valid_i,
    output logic                     instr_ready_o,
    input  logic [31:0]              instr_i,
    input  logic [NUM_LANES*96-1:0]  rs_i,
    input  logic [ID_W-1:0]          id_i,
    input  logic                     flush_i,
    output logic                     issue_valid_o,
    input  logic                     issue_ready_i,
    output issue_entry_t             issue_o,
    output logic                     illegal_o,
    output logic [ID_W-1:0]          illegal_id_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    issue_entry_t mem [DEPTH];
    issue_entry_t dec_entry;
    logic         dec_legal;
    logic         accept;
    logic         push;
    logic         pop;
    logic         full;
    logic         empty;
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    kronos_instr_decode #(
        .NUM_LANES  (NUM_LANES),
        .FUNCT7_MAX (FUNCT7_MAX),
        .ID_W       (ID_W)
    ) u_decode (
        .instr (instr_i),
        .rs    (rs_i),
        .id    (id_i),
        .legal (dec_legal),
        .entry (dec_entry)
    );

    assign full          = wr_ptr[AW] != rd_ptr[AW] && wr_ptr[AW-1:0] == rd_ptr[AW-1:0];
    assign empty         = wr_ptr == rd_ptr;
    assign instr_ready_o = !full && !flush_i;
    assign accept        = instr_valid_i && instr_ready_o;
    assign push          = accept && dec_legal;
    assign pop           = issue_valid_o && issue_ready_i && !flush_i;
    assign issue_valid_o = !empty;
    assign issue_o       = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign count_o       = wr_ptr - rd_ptr;

    // entry storage needs no reset: only slots between the pointers are ever read
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[AW-1:0]] <= dec_entry;
    end

    // pointer bookkeeping and the one-cycle illegal report; flush empties by catching rd up to wr
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            illegal_o    <= 1'b0;
            illegal_id_o <= '0;
        end else begin
            illegal_o <= accept && !dec_legal;
            if (accept && !dec_legal) illegal_id_o <= id_i;
            wr_ptr <= wr_ptr + {{AW{1'b0}}, push};
            rd_ptr <= flush_i ? wr_ptr : rd_ptr + {{AW{1'b0}}, pop};
        end
    end

endmodule

// File: tb/tb_kronos_issue_queue.sv
// tb_kronos_issue_queue: table-driven and sequence checks with a scoreboard on issue and illegal reports
module tb_kronos_issue_queue;
    import kronos_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         instr_valid = 1'b0;
    logic         flush = 1'b0;
    logic         issue_ready = 1'b0;
    logic [31:0]  instr = '0;
    logic [191:0] rs = '0;
    logic [3:0]   id = '0;
    logic         instr_ready_o;
    logic         issue_valid_o;
    logic         illegal_o;
    issue_entry_t issue_o;
    logic [3:0]   illegal_id_o;
    logic [2:0]   count_o;
    logic         acc_valid;
    int           total = 0;
    int           bad = 0;
    issue_entry_t exp_q[$];
    logic [3:0]   ill_q[$];

    typedef struct {
        logic [31:0] ins;
        logic [3:0]  tid;
        bit          leg;
        logic [6:0]  f7;
        logic [1:0]  f2;
        logic [11:0] imm;
    } vec_t;
    vec_t tbl[10];

    always #5 clk = ~clk;

    kronos_issue_queue dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .instr_valid_i (instr_valid),
        .instr_ready_o (instr_ready_o),
        .instr_i       (instr),
        .rs_i          (rs),
        .id_i          (id),
        .flush_i       (flush),
        .issue_valid_o (issue_valid_o),
        .issue_ready_i (issue_ready),
        .issue_o       (issue_o),
        .illegal_o     (illegal_o),
        .illegal_id_o  (illegal_id_o),
        .count_o       (count_o)
    );

    task automatic chk(input string nm, input logic [447:0] act, input logic [447:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, req);
        end
    endtask

    // caller is at posedge+1; returns at posedge+1 right after the accepting edge
    task automatic send(input logic [31:0] ins, input logic [3:0] tid, input bit leg,
                        input logic [6:0] f7, input logic [1:0] f2, input logic [11:0] imm);
        issue_entry_t e;
        int n;
        instr_valid = 1'b1;
        instr = ins;
        id = tid;
        rs = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        n = 0;
        @(negedge clk);
        while (!instr_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        acc_valid = issue_valid_o;
        if (!instr_ready_o) chk("accept_timeout", 448'(instr_ready_o), 448'd1);
        else if (leg) begin
            e = '0;
            e.opcode = kronos_op'(ins[6:0]);
            e.funct3 = ins[14:12];
            e.funct7 = f7;
            e.funct2 = f2;
            e.imm = imm;
            e.ops[0] = rs[95:0];
            e.ops[1] = rs[191:96];
            e.id = {4'd0, tid};
            exp_q.push_back(e);
        end else ill_q.push_back(tid);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    // scoreboard: every handshake and every illegal pulse must match the oldest expectation
    always @(negedge clk) begin
        if (issue_valid_o && issue_ready && !flush) begin
            if (exp_q.size() == 0) chk("unexpected_issue", 448'd1, 448'd0);
            else chk("issue_entry", 448'(issue_o), 448'(exp_q.pop_front()));
        end
        if (illegal_o) begin
            if (ill_q.size() == 0) chk("unexpected_illegal", 448'd1, 448'd0);
            else chk("illegal_id", 448'(illegal_id_o), 448'(ill_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'h0A00103B, 4'd3,  1'b1, 7'd5,  2'd0, 12'h000};
        tbl[1] = '{32'h5000103B, 4'd5,  1'b0, 7'd0,  2'd0, 12'h000};
        tbl[2] = '{32'h0000003B, 4'd6,  1'b0, 7'd0,  2'd0, 12'h000};
        tbl[3] = '{32'hABC0200B, 4'd7,  1'b1, 7'd0,  2'd0, 12'hABC};
        tbl[4] = '{32'h0400304B, 4'd8,  1'b1, 7'd0,  2'd2, 12'h000};
        tbl[5] = '{32'h4E00103B, 4'd9,  1'b1, 7'd39, 2'd0, 12'h000};
        tbl[6] = '{32'h0000107F, 4'd10, 1'b0, 7'd0,  2'd0, 12'h000};
        tbl[7] = '{32'hFFF0F00B, 4'd11, 1'b1, 7'd0,  2'd0, 12'hFFF};
        tbl[8] = '{32'hFFFFF04B, 4'd12, 1'b1, 7'd0,  2'd3, 12'h000};
        tbl[9] = '{32'h1230000B, 4'd13, 1'b0, 7'd0,  2'd0, 12'h000};

        #23 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 448'(instr_ready_o), 448'd1);
        chk("rst_valid", 448'(issue_valid_o), 448'd0);
        chk("rst_illegal", 448'(illegal_o), 448'd0);
        chk("rst_illegal_id", 448'(illegal_id_o), 448'd0);
        chk("rst_count", 448'(count_o), 448'd0);
        chk("rst_issue_zero", 448'(issue_o), 448'd0);

        @(posedge clk);
        #1 issue_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(tbl[i].ins, tbl[i].tid, tbl[i].leg, tbl[i].f7, tbl[i].f2, tbl[i].imm);
            chk("no_bypass", 448'(acc_valid), 448'd0);
            @(negedge clk);
            chk("vec_count", 448'(count_o), 448'(tbl[i].leg ? 3'd1 : 3'd0));
            chk("vec_valid", 448'(issue_valid_o), 448'(tbl[i].leg));
            @(posedge clk);
            #1;
        end

        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(32'h0000103B, 4'(i), 1'b1, 7'd0, 2'd0, 12'h0);
        @(negedge clk);
        chk("full_count", 448'(count_o), 448'd4);
        chk("full_ready", 448'(instr_ready_o), 448'd0);
        @(posedge clk);
        #1 issue_ready = 1'b1;
        send(32'h0000103B, 4'd4, 1'b1, 7'd0, 2'd0, 12'h0);
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
        chk("drain_left", 448'(exp_q.size()), 448'd0);
        @(negedge clk);
        chk("drain_valid", 448'(issue_valid_o), 448'd0);
        chk("empty_zero", 448'(issue_o), 448'd0);

        @(posedge clk);
        #1 issue_ready = 1'b0;
        send(32'h0020103B, 4'd1, 1'b1, 7'd0, 2'd0, 12'h0);
        send(32'h0040203B, 4'd2, 1'b1, 7'd0, 2'd0, 12'h0);
        @(negedge clk);
        chk("pp_count_before", 448'(count_o), 448'd2);
        @(posedge clk);
        #1 issue_ready = 1'b1;
        send(32'h0060303B, 4'd3, 1'b1, 7'd0, 2'd0, 12'h0);
        issue_ready = 1'b0;
        @(negedge clk);
        chk("pp_count_after", 448'(count_o), 448'd2);
        @(posedge clk);
        #1;
        send(32'h0080403B, 4'd4, 1'b1, 7'd0, 2'd0, 12'h0);
        send(32'h0000003B, 4'd9, 1'b0, 7'd0, 2'd0, 12'h0);
        flush = 1'b1;
        issue_ready = 1'b1;
        @(negedge clk);
        chk("flush_count_before", 448'(count_o), 448'd3);
        chk("flush_ready", 448'(instr_ready_o), 448'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_count", 448'(count_o), 448'd0);
        chk("flush_valid", 448'(issue_valid_o), 448'd0);
        chk("flush_illegal_seen", 448'(ill_q.size()), 448'd0);

        @(posedge clk);
        #1 issue_ready = 1'b0;
        send(32'h0000503B, 4'd5, 1'b1, 7'd0, 2'd0, 12'h0);
        send(32'h0000603B, 4'd6, 1'b1, 7'd0, 2'd0, 12'h0);
        send(32'h00000000, 4'd7, 1'b0, 7'd0, 2'd0, 12'h0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 448'(issue_valid_o), 448'd0);
        chk("mid_rst_count", 448'(count_o), 448'd0);
        chk("mid_rst_illegal", 448'(illegal_o), 448'd0);
        chk("mid_rst_issue_zero", 448'(issue_o), 448'd0);
        exp_q.delete();
        ill_q.delete();
        #3 rst = 1'b0;
        @(posedge clk);
        #1 issue_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_valid", 448'(issue_valid_o), 448'd0);
        chk("post_rst_ready", 448'(instr_ready_o), 448'd1);
        chk("final_exp_q", 448'(exp_q.size()), 448'd0);
        chk("final_ill_q", 448'(ill_q.size()), 448'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kronos_issue_queue.md
KRONOS_ISSUE_QUEUE -- requirements
Module: kronos_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, >= 2).
REQ-002 SHALL have parameter NUM_LANES, default 2, meaning operand lanes, each carrying rs1/rs2/rs3 (generalises the fixed _0/_1 pair of in_t).
REQ-003 SHALL have parameter FUNCT7_MAX, default 39, meaning the highest legal R-type funct7.
REQ-004 SHALL have parameter ID_W, default 4, meaning instruction tag width.
REQ-005 SHALL have port clk_i, input, 1 bit: the one clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port instr_valid_i, input, 1 bit: offered instruction is valid.
REQ-008 SHALL have port instr_ready_o, output, 1 bit: queue accepts this cycle.
REQ-009 SHALL have port instr_i, input, 32 bits: raw instruction_u.
REQ-010 SHALL have port rs_i, input, NUM_LANES*3*32 bits: lane operands, lane 0 in the LSBs, order rs1,rs2,rs3 from the LSB.
REQ-011 SHALL have port id_i, input, ID_W bits: tag.
REQ-012 SHALL have port flush_i, input, 1 bit: discard all queued entries.
REQ-013 SHALL have port issue_valid_o, output, 1 bit, plus issue_ready_i, input, 1 bit: head handshake.
REQ-014 SHALL have port issue_o, output, issue_entry_t: opcode, funct3, funct7, funct2, immediate, operands, id.
REQ-015 SHALL have port illegal_o, output, 1 bit, plus illegal_id_o, output, ID_W bits: rejected-instruction report.
REQ-016 SHALL have port count_o, output, $clog2(DEPTH)+1 bits: occupancy.

Function
REQ-017 SHALL accept on instr_valid_i && instr_ready_o; instr_ready_o = !full && !flush_i (no dependence on issue_ready_i).
REQ-018 SHALL mark legal only: opcode in {kronos_I, kronos_R, kronos_R4}, funct3 != 000, and for kronos_R funct7 <= FUNCT7_MAX.
REQ-019 SHALL enqueue a legal accepted instruction with unused fields zeroed: I gives funct7=0, funct2=0; R gives funct2=0, imm=0; R4 gives funct7=0, imm=0.
REQ-020 SHALL NOT enqueue an illegal accepted instruction; illegal_o SHALL pulse high for exactly the next cycle, with illegal_id_o = its id.
REQ-021 SHALL present an entry at issue_valid_o no earlier than the cycle after acceptance (1-cycle minimum latency), in FIFO order.
REQ-022 SHALL pop the head on issue_valid_o && issue_ready_i; issue_o SHALL be held stable while valid and not ready.
REQ-023 SHALL handle simultaneous push and pop (not full) with count unchanged and both performed.
REQ-024 SHALL keep read/write pointers with one extra wrap bit; full = MSBs differ and the rest are equal; empty = equal.
REQ-025 SHALL, on flush_i, set the queue empty at the next edge, ignore any pop that cycle, and drop no illegal_o pulse already pending.
REQ-026 SHALL drive issue_o to all zeros when empty.

Reset
REQ-027 SHALL, on rst_i, asynchronously clear pointers and count, and drive instr_ready_o=1 (once rst_i is low), issue_valid_o=0, illegal_o=0, illegal_id_o=0, count_o=0.
REQ-028 SHALL, when reset asserts mid-operation, lose all queued entries, with no issue or illegal pulse after release.

Structure
REQ-029 SHALL place issue_entry_t, the KRONOS_FUNCT7_MAX default constant and the lane operand struct in kronos_pkg, reusing instruction_u and kronos_op.
REQ-030 SHALL use one combinational sub-module, kronos_instr_decode (raw in, legal flag plus normalised issue_entry_t out).

Verification
REQ-031 SHALL test: instr 0x0A00103B (R, f3=1, f7=5), id 3 -> issue next cycle with funct7=5, funct2=0, imm=0, id=3.
REQ-032 SHALL test: 0x5000103B (f7=40) then 0x0000003B (f3=0) -> two illegal_o pulses with ids in order, count_o stays 0.
REQ-033 SHALL test: 0xABC0200B (I), then 0x0400304B (R4) -> imm=0xABC with funct7=0; then funct2=2 with imm=0, issued in order.
REQ-034 SHALL test: DEPTH=4, issue_ready_i=0, push 5 -> instr_ready_o low after 4, count_o=4; release -> ids drain in order and pointers wrap.
REQ-035 SHALL test: count_o=2, push and pop in the same cycle -> count_o stays 2; flush_i with 3 queued -> count_o=0 and issue_valid_o=0 next cycle.
REQ-036 SHALL test: rst_i asserted mid-stream between clock edges -> outputs reset immediately, with no residual issue after release.
